// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_arith_pkg
// Description : Shared types and defaults for the bit-serial arithmetic units.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_arith_pkg;

  localparam int SERIAL_ARITH_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor
// Description : Combinational 1-bit full subtractor built from two
//               half-subtractor stages.
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic hs1_d;
  logic hs1_b;
  logic hs2_b;

  assign hs1_d = x ^ y;
  assign hs1_b = ~x & y;
  assign d     = hs1_d ^ bin;
  assign hs2_b = ~hs1_d & bin;
  assign bout  = hs1_b | hs2_b;

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial a - b, LSB first, one bit per clock through a
//               single full-subtractor cell. Valid/ready on both sides.
//               SERIAL_SUB_SIGNED_OVF_EN enables the signed-overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SERIAL_ARITH_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bff_q, bff_d;
  logic             borrow_q, borrow_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             fs_d;
  logic             fs_bout;
  logic             last_bit;

  full_subtractor u_fs (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (bff_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  assign last_bit = (cnt_q == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      res_q       <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      bff_q       <= 1'b0;
      borrow_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      res_q       <= res_d;
      diff_q      <= diff_d;
      cnt_q       <= cnt_d;
      bff_q       <= bff_d;
      borrow_q    <= borrow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    res_d       = res_q;
    diff_d      = diff_q;
    cnt_d       = cnt_q;
    bff_d       = bff_q;
    borrow_d    = borrow_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d       = a;
          sb_d       = b;
          bff_d      = 1'b0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        // Result bits enter at the MSB so the LSB-first stream lands in place.
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = {fs_d, res_q[WIDTH-1:1]};
        bff_d = fs_bout;
        cnt_d = cnt_q + 1'b1;
        if (last_bit) begin
          diff_d      = res_d;
          borrow_d    = fs_bout;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic ovf_q;

  // On the last bit the cell operands are the sign bits of a and b.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && last_bit) begin
      ovf_q <= (sa_q[0] ^ sb_q[0]) & (sa_q[0] ^ fs_d);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;

endmodule
`default_nettype wire
